vga_sync_generator: RTL and testbench



---
 rtl/vga_sync_generator_pkg.sv | 39 +++
 rtl/vga_sync_generator_if.sv | 52 +++++
 rtl/vga_sync_axis_counter.sv | 54 +++++
 rtl/vga_sync_generator.sv | 154 +++++++++++++++
 tb/tb_vga_sync_generator.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_generator_pkg.sv
// Shared timing defaults (640x480@60), axis helpers and FSM encoding for the VGA sync generator.
// Optional Frame_Count output is enabled with VGA_SYNC_FRAME_COUNTER_EN.
package vga_sync_generator_pkg;

    localparam int unsigned DEF_H_VISIBLE     = 640;
    localparam int unsigned DEF_H_FRONT       = 16;
    localparam int unsigned DEF_H_SYNC        = 96;
    localparam int unsigned DEF_H_BACK        = 48;
    localparam int unsigned DEF_V_VISIBLE     = 480;
    localparam int unsigned DEF_V_FRONT       = 10;
    localparam int unsigned DEF_V_SYNC        = 2;
    localparam int unsigned DEF_V_BACK        = 33;
    localparam bit          DEF_SYNC_POLARITY = 1'b0;
    localparam int unsigned DEF_COUNTER_WIDTH = 10;

    localparam int unsigned FRAME_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Axis order is visible, front porch, sync, back porch.
    function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned visible, input int unsigned front);
        return visible + front;
    endfunction

    function automatic int unsigned sync_end(input int unsigned visible, input int unsigned front,
                                             input int unsigned sync);
        return visible + front + sync;
    endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Timing bus between the sync generator (master) and the display path (slave).
// Frame_Count is present only when VGA_SYNC_FRAME_COUNTER_EN is defined.
interface vga_sync_generator_if #(
    parameter int unsigned COUNTER_WIDTH = vga_sync_generator_pkg::DEF_COUNTER_WIDTH
);
    logic                     Pixel_Tick;
    logic                     Enable;
    logic                     HSync;
    logic                     VSync;
    logic                     Active_Video;
    logic [COUNTER_WIDTH-1:0] Pixel_X;
    logic [COUNTER_WIDTH-1:0] Pixel_Y;
    logic                     Line_Start;
    logic                     Frame_Start;
    logic                     Running;
`ifdef VGA_SYNC_FRAME_COUNTER_EN
    logic [vga_sync_generator_pkg::FRAME_COUNT_WIDTH-1:0] Frame_Count;
`endif

    modport master (
        input  Pixel_Tick,
        input  Enable,
        output HSync,
        output VSync,
        output Active_Video,
        output Pixel_X,
        output Pixel_Y,
        output Line_Start,
        output Frame_Start,
        output Running
`ifdef VGA_SYNC_FRAME_COUNTER_EN
        , output Frame_Count
`endif
    );

    modport slave (
        output Pixel_Tick,
        output Enable,
        input  HSync,
        input  VSync,
        input  Active_Video,
        input  Pixel_X,
        input  Pixel_Y,
        input  Line_Start,
        input  Frame_Start,
        input  Running
`ifdef VGA_SYNC_FRAME_COUNTER_EN
        , input Frame_Count
`endif
    );

endinterface

// File: rtl/vga_sync_axis_counter.sv
// One timing axis: wrapping position counter plus next-value sync/visible decode,
// so the parent can register its outputs on the same edge as the count.
module vga_sync_axis_counter
    import vga_sync_generator_pkg::*;
#(
    parameter int unsigned VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned FRONT    = DEF_H_FRONT,
    parameter int unsigned SYNC     = DEF_H_SYNC,
    parameter int unsigned BACK     = DEF_H_BACK,
    parameter bit          POLARITY = DEF_SYNC_POLARITY,
    parameter int unsigned WIDTH    = DEF_COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             last_c,
    output logic             next_sync_c,
    output logic             next_visible_c
);

    localparam int unsigned TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam int unsigned S_START = sync_start(VISIBLE, FRONT);
    localparam int unsigned S_END   = sync_end(VISIBLE, FRONT, SYNC);

    logic [WIDTH-1:0] count_d_c;
    logic             in_sync_c;

    // Kept separate from the next-count logic: the parent derives en from last_c.
    assign last_c = (count == WIDTH'(TOTAL - 1));

    always_comb begin
        count_d_c = count;
        if (clear) begin
            count_d_c = '0;
        end else if (en) begin
            count_d_c = last_c ? '0 : count + WIDTH'(1);
        end
    end

    assign in_sync_c      = (count_d_c >= WIDTH'(S_START)) && (count_d_c < WIDTH'(S_END));
    assign next_sync_c    = in_sync_c ? POLARITY : ~POLARITY;
    assign next_visible_c = (count_d_c < WIDTH'(VISIBLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_d_c;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA HSync/VSync and pixel-coordinate generator with frame-aligned start/stop.
// Define VGA_SYNC_FRAME_COUNTER_EN to add the 16-bit Frame_Count output.
module vga_sync_generator
    import vga_sync_generator_pkg::*;
#(
    parameter int unsigned H_VISIBLE     = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT       = DEF_H_FRONT,
    parameter int unsigned H_SYNC        = DEF_H_SYNC,
    parameter int unsigned H_BACK        = DEF_H_BACK,
    parameter int unsigned V_VISIBLE     = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT       = DEF_V_FRONT,
    parameter int unsigned V_SYNC        = DEF_V_SYNC,
    parameter int unsigned V_BACK        = DEF_V_BACK,
    parameter bit          SYNC_POLARITY = DEF_SYNC_POLARITY,
    parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input logic                  Clk,
    input logic                  Rst,
    vga_sync_generator_if.master bus
);

    state_e state;
    state_e state_d_c;

    logic [COUNTER_WIDTH-1:0] h_count;
    logic [COUNTER_WIDTH-1:0] v_count;
    logic h_last_c, v_last_c;
    logic h_sync_nx_c, v_sync_nx_c, h_vis_nx_c, v_vis_nx_c;

    logic counting_c, clear_c, start_c, h_en_c, v_en_c, frame_wrap_c;
    logic live_c, hsync_d_c, vsync_d_c, active_d_c, line_start_d_c, frame_start_d_c;

    logic hsync, vsync, active_video, line_start, frame_start, running;

    assign counting_c   = (state != ST_IDLE);
    assign clear_c      = ~counting_c;
    assign start_c      = (state == ST_IDLE) & bus.Enable & bus.Pixel_Tick;
    assign h_en_c       = counting_c & bus.Pixel_Tick;
    assign v_en_c       = h_en_c & h_last_c;
    assign frame_wrap_c = v_en_c & v_last_c;

    vga_sync_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POLARITY(SYNC_POLARITY),
        .WIDTH   (COUNTER_WIDTH)
    ) u_h_axis (
        .clk           (Clk),
        .rst_n         (Rst),
        .en            (h_en_c),
        .clear         (clear_c),
        .count         (h_count),
        .last_c        (h_last_c),
        .next_sync_c   (h_sync_nx_c),
        .next_visible_c(h_vis_nx_c)
    );

    vga_sync_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POLARITY(SYNC_POLARITY),
        .WIDTH   (COUNTER_WIDTH)
    ) u_v_axis (
        .clk           (Clk),
        .rst_n         (Rst),
        .en            (v_en_c),
        .clear         (clear_c),
        .count         (v_count),
        .last_c        (v_last_c),
        .next_sync_c   (v_sync_nx_c),
        .next_visible_c(v_vis_nx_c)
    );

    // Stop requests only take effect at the end of a complete frame.
    always_comb begin
        state_d_c = state;
        case (state)
            ST_IDLE:  if (start_c) state_d_c = ST_RUN;
            ST_RUN:   if (!bus.Enable) state_d_c = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.Enable) begin
                    state_d_c = ST_RUN;
                end else if (frame_wrap_c) begin
                    state_d_c = ST_IDLE;
                end
            end
            default:  state_d_c = ST_IDLE;
        endcase
    end

    // Output next-values track the next counter values; IDLE forces the quiet pattern.
    always_comb begin
        live_c     = (state_d_c != ST_IDLE);
        hsync_d_c  = ~SYNC_POLARITY;
        vsync_d_c  = ~SYNC_POLARITY;
        active_d_c = 1'b0;
        if (live_c) begin
            hsync_d_c  = h_sync_nx_c;
            vsync_d_c  = v_sync_nx_c;
            active_d_c = h_vis_nx_c & v_vis_nx_c;
        end
        line_start_d_c  = start_c | (v_en_c & live_c);
        frame_start_d_c = start_c | (frame_wrap_c & live_c);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= ST_IDLE;
            hsync        <= ~SYNC_POLARITY;
            vsync        <= ~SYNC_POLARITY;
            active_video <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= state_d_c;
            hsync        <= hsync_d_c;
            vsync        <= vsync_d_c;
            active_video <= active_d_c;
            line_start   <= line_start_d_c;
            frame_start  <= frame_start_d_c;
            running      <= live_c;
        end
    end

    assign bus.HSync        = hsync;
    assign bus.VSync        = vsync;
    assign bus.Active_Video = active_video;
    assign bus.Pixel_X      = h_count;
    assign bus.Pixel_Y      = v_count;
    assign bus.Line_Start   = line_start;
    assign bus.Frame_Start  = frame_start;
    assign bus.Running      = running;

`ifdef VGA_SYNC_FRAME_COUNTER_EN
    logic [FRAME_COUNT_WIDTH-1:0] frame_count;

    // Counts every emitted Frame_Start; naturally holds while idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            frame_count <= '0;
        end else if (frame_start_d_c) begin
            frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
        end
    end

    assign bus.Frame_Count = frame_count;
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a reduced-timing instance checked every cycle against a
// linear-pixel-index model, plus a default 640x480 instance pinned with literal expectations.
module tb_vga_sync_generator;

    localparam int T_HV = 16, T_HF = 4, T_HS = 6, T_HB = 6;
    localparam int T_VV = 12, T_VF = 2, T_VS = 2, T_VB = 3;
    localparam int T_HT = T_HV + T_HF + T_HS + T_HB;   // 32
    localparam int T_VT = T_VV + T_VF + T_VS + T_VB;   // 19
    localparam int T_FRAME = T_HT * T_VT;               // 608

    logic clk;
    logic rst_n;
    logic tick;
    logic enable;

    int vectors = 0;
    int miscompares = 0;

    // Model: position as a linear index into the frame.
    int mp = 0;
    bit mrun = 0, mdrain = 0, mfs = 0, mls = 0;
    int mfc = 0;

    vga_sync_generator_if #(.COUNTER_WIDTH(10)) bus ();
    vga_sync_generator_if #(.COUNTER_WIDTH(10)) bus_f ();

    assign bus.Pixel_Tick   = tick;
    assign bus.Enable       = enable;
    assign bus_f.Pixel_Tick = tick;
    assign bus_f.Enable     = enable;

    vga_sync_generator #(
        .H_VISIBLE(T_HV), .H_FRONT(T_HF), .H_SYNC(T_HS), .H_BACK(T_HB),
        .V_VISIBLE(T_VV), .V_FRONT(T_VF), .V_SYNC(T_VS), .V_BACK(T_VB),
        .SYNC_POLARITY(1'b0), .COUNTER_WIDTH(10)
    ) dut (
        .Clk(clk),
        .Rst(rst_n),
        .bus(bus)
    );

    vga_sync_generator dut_f (
        .Clk(clk),
        .Rst(rst_n),
        .bus(bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit rnd_tick();
        return $urandom_range(0, 3) != 0;
    endfunction

    // Model update on each edge, then compare every output shortly after.
    always @(posedge clk) begin
        bit wrapped;
        int x, y;
        if (!rst_n) begin
            mp = 0; mrun = 0; mdrain = 0; mfs = 0; mls = 0; mfc = 0;
        end else begin
            mfs = 0;
            mls = 0;
            if (!mrun) begin
                if (enable && tick) begin
                    mrun = 1; mdrain = 0; mp = 0; mfs = 1; mls = 1;
                end
            end else begin
                wrapped = 0;
                if (tick) begin
                    mp = mp + 1;
                    if (mp == T_FRAME) begin
                        mp = 0;
                        wrapped = 1;
                    end
                    mls = (mp % T_HT) == 0;
                    mfs = wrapped;
                end
                if (mdrain && !enable && wrapped) begin
                    mrun = 0; mfs = 0; mls = 0;
                end else begin
                    mdrain = !enable;
                end
            end
            if (mfs) mfc = (mfc + 1) % 65536;
        end
        #1;
        x = mp % T_HT;
        y = mp / T_HT;
        check("px", int'(bus.Pixel_X), x);
        check("py", int'(bus.Pixel_Y), y);
        check("hsync", int'(bus.HSync), (mrun && x >= T_HV + T_HF && x < T_HV + T_HF + T_HS) ? 0 : 1);
        check("vsync", int'(bus.VSync), (mrun && y >= T_VV + T_VF && y < T_VV + T_VF + T_VS) ? 0 : 1);
        check("active", int'(bus.Active_Video), (mrun && x < T_HV && y < T_VV) ? 1 : 0);
        check("line_start", int'(bus.Line_Start), int'(mls));
        check("frame_start", int'(bus.Frame_Start), int'(mfs));
        check("running", int'(bus.Running), int'(mrun));
`ifdef VGA_SYNC_FRAME_COUNTER_EN
        check("frame_count", int'(bus.Frame_Count), mfc);
`endif
    end

    task automatic cyc(input bit t, input bit e);
        @(negedge clk);
        tick = t;
        enable = e;
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(input int target, input bit e, input int budget);
        int n;
        n = 0;
        while (!(mrun && mp == target) && n < budget) begin
            cyc(rnd_tick(), e);
            n++;
        end
        check("run_to_reached", int'(mrun && mp == target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (mrun && n < budget) begin
            cyc(rnd_tick(), 1'b0);
            n++;
        end
        check("idle_reached", int'(mrun), 0);
    endtask

    initial begin
        int av_n, ls_n, fs_n;
        bit e;
        rst_n = 1'b0;
        tick = 1'b0;
        enable = 1'b0;

        // Reset values and idle with ticks but no Enable
        repeat (3) cyc(1'b0, 1'b0);
        check("rst_px", int'(bus.Pixel_X), 0);
        check("rst_hs", int'(bus.HSync), 1);
        check("rst_run", int'(bus.Running), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) cyc((i % 4) == 0, 1'b0);
        check("idle_run", int'(bus.Running), 0);
        check("idle_av", int'(bus.Active_Video), 0);

        // Default 640x480 timing pinned by literals over two lines
        for (int k = 0; k < 1700; k++) begin
            int x, y, ks;
            cyc(1'b1, 1'b1);
            x = k % 800;
            y = k / 800;
            ks = k % 608;
            check("f_px", int'(bus_f.Pixel_X), x);
            check("f_py", int'(bus_f.Pixel_Y), y);
            check("f_hs", int'(bus_f.HSync), (x >= 656 && x <= 751) ? 0 : 1);
            check("f_vs", int'(bus_f.VSync), 1);
            check("f_av", int'(bus_f.Active_Video), (x < 640) ? 1 : 0);
            check("f_ls", int'(bus_f.Line_Start), (x == 0) ? 1 : 0);
            check("f_fs", int'(bus_f.Frame_Start), (k == 0) ? 1 : 0);
            check("s_fs", int'(bus.Frame_Start), (ks == 0) ? 1 : 0);
            check("s_vs", int'(bus.VSync), (ks / 32 == 14 || ks / 32 == 15) ? 0 : 1);
        end

        // Drain scenarios
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1);
        run_to(5 * T_HT, 1'b1, 2000);
        cyc(1'b1, 1'b0);
        wait_idle(2000);
        repeat (40) cyc(rnd_tick(), 1'b0);
        cyc(1'b1, 1'b1);
        run_to(3 * T_HT, 1'b1, 2000);
        cyc(1'b1, 1'b0);
        run_to(10 * T_HT, 1'b0, 2000);
        cyc(rnd_tick(), 1'b1);
        run_to(T_FRAME - 1, 1'b1, 2000);
        cyc(1'b1, 1'b0);
        check("wrapdrop_fs", int'(bus.Frame_Start), 1);
        check("wrapdrop_run", int'(bus.Running), 1);
        run_to(T_FRAME - 1, 1'b0, 2000);
        cyc(1'b1, 1'b1);
        check("drainrise_fs", int'(bus.Frame_Start), 1);
        run_to(T_FRAME - 1, 1'b1, 2000);
        cyc(1'b1, 1'b0);
        run_to(T_FRAME - 1, 1'b0, 2000);
        cyc(1'b1, 1'b0);
        check("drainend_fs", int'(bus.Frame_Start), 0);
        check("drainend_ls", int'(bus.Line_Start), 0);
        check("drainend_run", int'(bus.Running), 0);

        // One full frame from IDLE: visible area and pulse counts
        av_n = 0; ls_n = 0; fs_n = 0;
        for (int i = 0; i < T_FRAME; i++) begin
            cyc(1'b1, 1'b1);
            av_n += int'(bus.Active_Video);
            ls_n += int'(bus.Line_Start);
            fs_n += int'(bus.Frame_Start);
        end
        check("frame_active", av_n, 192);
        check("frame_lines", ls_n, 19);
        check("frame_starts", fs_n, 1);

        // Reset mid-frame
        run_to(6 * T_HT + 8, 1'b1, 2000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_px", int'(bus.Pixel_X), 0);
        check("midrst_py", int'(bus.Pixel_Y), 0);
        check("midrst_run", int'(bus.Running), 0);
        check("midrst_av", int'(bus.Active_Video), 0);
        repeat (3) cyc(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick = 1'b0;
        enable = 1'b0;
        cyc(1'b1, 1'b1);
        check("restart_fs", int'(bus.Frame_Start), 1);
        check("restart_px", int'(bus.Pixel_X), 0);
        repeat (700) cyc(rnd_tick(), 1'b1);

        // Random Enable, tick and reset traffic
        e = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 999) == 0) e = !e;
            rst_n = ($urandom_range(0, 3999) != 0);
            cyc(rnd_tick(), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
